// File: rtl/seq_alu_if.sv
// Handshake bundle between the operand register file, seq_alu and the
// result/flag register stage. The producer/consumer side is the master.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             op_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags, op_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags, op_err
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU with iterative multiply/divide.
// Single-cycle ops finish on the accept edge; mul/div run WIDTH steps.
//
// state | meaning
// IDLE  | ready for a new op; single-cycle ops resolve on accept
// CALC  | one shift-add (mul) or restoring subtract-shift (div) step per cycle
// DONE  | result/flags/op_err held with out_valid until out_ready
module seq_alu #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input logic    clk,
    input logic    rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       op_q, op_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0] mq_q, mq_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [WIDTH-1:0] result_q, result_nxt;
    logic [3:0]       flags_q, flags_nxt;
    logic             err_q, err_nxt;

    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf, alu_of, alu_err, is_muldiv;

    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge, div_op;
    logic [WIDTH-1:0] step_acc, step_mq, fin_res;

    // Single-cycle function of the operands currently on the input channel.
    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        shamt     = bus.b[SHW-1:0];
        alu_res   = '0;
        alu_cf    = 1'b0;
        alu_of    = 1'b0;
        alu_err   = 1'b0;
        is_muldiv = 1'b0;
        case (bus.op)
            4'b0000: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b1000: begin
                alu_res = diff[WIDTH-1:0];
                alu_cf  = diff[WIDTH];
                alu_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0001: alu_res = bus.a << shamt;
            4'b0101: alu_res = bus.a >> shamt;
            4'b1101: alu_res = $signed(bus.a) >>> shamt;
            4'b0010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'b0100: alu_res = bus.a ^ bus.b;
            4'b0110: alu_res = bus.a | bus.b;
            4'b0111: alu_res = bus.a & bus.b;
            4'b1001, 4'b1010, 4'b1011, 4'b1100: begin
                if (ENABLE_MULDIV) is_muldiv = 1'b1;
                else               alu_err   = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

    // One iteration step. Mul keeps {acc,mq} as the partial product shifting
    // right; div shifts the dividend out of mq into acc and quotient bits in.
    // The divide compare uses the full WIDTH+1 shifted value so that a zero
    // divisor never borrows, leaving quotient all ones and remainder = a.
    always_comb begin
        div_op    = (op_q == 4'b1011) || (op_q == 4'b1100);
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        if (div_op) begin
            step_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        fin_res = ((op_q == 4'b1010) || (op_q == 4'b1100)) ? step_acc : step_mq;
    end

    // Next-state and datapath-next logic.
    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        b_nxt      = b_q;
        acc_nxt    = acc_q;
        mq_nxt     = mq_q;
        cnt_nxt    = cnt_q;
        result_nxt = result_q;
        flags_nxt  = flags_q;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    op_nxt  = bus.op;
                    b_nxt   = bus.b;
                    mq_nxt  = bus.a;
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    if (is_muldiv) begin
                        state_nxt = CALC;
                    end else begin
                        state_nxt  = DONE;
                        result_nxt = alu_res;
                        flags_nxt  = {alu_of, alu_cf, alu_res[WIDTH-1], (alu_res == '0)};
                        err_nxt    = alu_err;
                    end
                end
            end
            CALC: begin
                acc_nxt = step_acc;
                mq_nxt  = step_mq;
                cnt_nxt = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_nxt  = DONE;
                    result_nxt = fin_res;
                    flags_nxt  = {1'b0, ((op_q == 4'b1010) && (fin_res != '0)),
                                  fin_res[WIDTH-1], (fin_res == '0)};
                    err_nxt    = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand, iteration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            op_q     <= op_nxt;
            b_q      <= b_nxt;
            acc_q    <= acc_nxt;
            mq_q     <= mq_nxt;
            cnt_q    <= cnt_nxt;
            result_q <= result_nxt;
            flags_q  <= flags_nxt;
            err_q    <= err_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.op_err    = err_q;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the team's single-cycle 32-bit ALU and its operand/result registers. It accepts an operand pair and opcode on a valid/ready input channel and returns the result and flags on a valid/ready output channel. Single-cycle ops have a one-cycle latency. It adds iterative multiply and divide ops, run by an internal state machine. It sits between the operand register file and the result/flag register stage.

Parameters:
WIDTH, 32, datapath width in bits (>=8).
ENABLE_MULDIV, 1, when 0 the opcodes 1001/1010/1011/1100 are illegal.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand pair and opcode valid
in_ready  output  1  block can accept a new op
op  input  4  opcode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  result word
flags  output  4  [0]=ZF, [1]=SF, [2]=CF, [3]=OF
op_err  output  1  opcode was illegal; qualified by out_valid

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset forces: state IDLE, out_valid=0, result=0, flags=0, op_err=0, all internal operand/iteration registers=0. in_ready=1 while in IDLE, including during reset. A reset mid-operation aborts the op silently with no output.
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b and op.
    - Single-cycle or illegal op: compute and go to DONE.
    - Mul/div op: go to CALC with the iteration counter set to 0.
  - CALC: in_ready=0. Do one shift-add (mul) or one restoring subtract-shift (div) step per cycle. After WIDTH steps, go to DONE.
  - DONE: out_valid=1, in_ready=0. result/flags/op_err stay stable until out_ready=1, then go to IDLE.
- Latency from accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - Mul/div ops: WIDTH+1 cycles.
- Throughput is at most one op per 2 cycles. No accept happens in the same cycle as a handoff.
- After handoff, result and flags hold their last values; out_valid drops to 0.
- Opcodes:
  - 0000 add; 1000 sub.
  - 0001 sll; 0101 srl (logical); 1101 sra (arithmetic). Shift amount = b[clog2(WIDTH)-1:0]; upper bits of b ignored.
  - 0010 slt (signed), 0011 sltu: result 1 or 0, zero-extended.
  - 0100 xor; 0110 or; 0111 and.
  - 1001 mul: low WIDTH bits of unsigned a*b.
  - 1010 mulhu: high WIDTH bits of unsigned a*b.
  - 1011 divu: quotient; 1100 remu: remainder.
  - Divide by zero: quotient = all ones, remainder = a, CF=0, no error.
  - All other opcodes (and mul/div when ENABLE_MULDIV=0): result=0, op_err=1, take the single-cycle path.
- Flags:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - CF: add = carry out of bit WIDTH-1; sub = borrow (a<b unsigned); mulhu = (result!=0); all others 0.
  - OF: add/sub = signed overflow (operand signs agree, for sub after inverting b, and result sign differs); all others 0.
- in_valid while in_ready=0 is ignored. The producer must hold its request until it sees in_ready.

Test Plan:
- WIDTH=32, reset, then add a=0x7FFFFFFF b=1 -> out_valid 1 cycle after accept; result=0x80000000, flags SF=1 OF=1 CF=0 ZF=0.
- sub a=5 b=10 -> result=0xFFFFFFFB, CF=1, SF=1, OF=0. Then sub a=10 b=10 -> result=0, ZF=1, CF=0.
- sra a=0x80000000 b=0x24 (amount 4) -> result=0xF8000000. srl with the same inputs -> result=0x08000000. slt a=0xFFFFFFFF b=1 -> 1; sltu with the same inputs -> 0.
- mul a=20 b=15 -> result=300, out_valid exactly 33 cycles after accept, in_ready=0 throughout. mulhu a=0xFFFFFFFF b=2 -> result=1, CF=1. divu a=20 b=3 -> result=6; remu -> result=2. divu a=7 b=0 -> result=0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable and in_ready=0. Then out_ready=1 -> next cycle in_ready=1, out_valid=0. Opcode 1110 -> op_err=1, result=0, ZF=1.
- rst_n low for 1 cycle at iteration 10 of a divu -> out_valid stays 0, state is IDLE, result=0. A following add a=5 b=10 -> result=15.
